// File: rtl/mem_access_pkg.sv
// mem_access_pkg: size codes, FSM states and big-endian lane helpers for the memory access unit
package mem_access_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL = 2'b11;
  localparam logic [1:0] LANE_LAST_B = 2'd3;
  localparam logic [1:0] LANE_LAST_H = 2'd2;
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;
  // Big-endian: byte k sits (3-k) bytes above bit 0, half at offset k sits (2-k) bytes above
  function automatic logic [4:0] lane_shift(logic [1:0] size, logic [1:0] ofs);
    return size == SZ_BYTE ? {LANE_LAST_B - ofs, 3'b000} : size == SZ_HALF ? {LANE_LAST_H - ofs, 3'b000} : 5'd0;
  endfunction
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/response handshake and data memory bus of the memory access unit
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic req_valid, req_ready, req_write, req_unsigned;
  logic [1:0] req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0] req_wdata;
  logic resp_valid, resp_misaligned;
  logic [31:0] resp_rdata;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0] mem_write_data, mem_read_data;
  logic mem_read_en, mem_write_en;
  modport slave (
    input req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_misaligned, mem_address, mem_write_data, mem_read_en, mem_write_en
  );
  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
    input req_ready, resp_valid, resp_rdata, resp_misaligned, mem_address, mem_write_data, mem_read_en, mem_write_en
  );
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: big-endian lane extract/extend for loads, lane merge for stores, alignment check
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  ofs_i,
  input  logic        unsigned_i,
  input  logic [31:0] rword_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o,
  output logic        misaligned_o
);
  logic [4:0] sh;
  logic [31:0] lane, mask;
  assign sh = lane_shift(size_i, ofs_i);
  assign lane = rword_i >> sh;
  assign mask = (size_i == SZ_BYTE ? 32'h0000_00FF : size_i == SZ_HALF ? 32'h0000_FFFF : 32'hFFFF_FFFF) << sh;
  assign load_o = size_i == SZ_BYTE ? {{24{~unsigned_i & lane[7]}}, lane[7:0]} :
                  size_i == SZ_HALF ? {{16{~unsigned_i & lane[15]}}, lane[15:0]} : lane;
  assign merge_o = (rword_i & ~mask) | ((wdata_i << sh) & mask);
  assign misaligned_o = size_i == SZ_ILL | (size_i == SZ_HALF & ofs_i[0]) | (size_i == SZ_WORD & |ofs_i);
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator between the MEM stage and word-wide data memory;
// sub-word stores are done as read-modify-write of the containing word.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int READ_WAIT = 0,
  parameter int ADDR_W = 32
) (
  input logic clk,
  input logic reset,
  mem_access_unit_if.slave bus
);
  localparam int CW = $clog2(READ_WAIT + 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(READ_WAIT);
  state_e state_q;
  logic write_q, uns_q, mis_q;
  logic [1:0] size_q, ofs_q;
  logic [CW-1:0] cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0] wdata_q, mem_wdata_q, rdata_q;
  logic idle, mis;
  logic [1:0] sz, ofs;
  logic [31:0] load_data, merged;
  assign idle = state_q == IDLE;
  // The aligner checks the incoming request while idle and the held request afterwards
  assign sz = idle ? bus.req_size : size_q;
  assign ofs = idle ? bus.req_addr[1:0] : ofs_q;
  mem_lane_align u_align (
    .size_i(sz), .ofs_i(ofs), .unsigned_i(uns_q), .rword_i(bus.mem_read_data), .wdata_i(wdata_q),
    .load_o(load_data), .merge_o(merged), .misaligned_o(mis)
  );
  assign bus.req_ready = idle;
  assign bus.mem_read_en = state_q == RD;
  assign bus.mem_write_en = state_q == WR;
  assign bus.resp_valid = state_q == RESP;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_misaligned = mis_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_write_data = mem_wdata_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      uns_q <= 1'b0;
      mis_q <= 1'b0;
      size_q <= '0;
      ofs_q <= '0;
      cnt_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      mem_wdata_q <= '0;
      rdata_q <= '0;
    end else
      case (state_q)
        IDLE: if (bus.req_valid) begin
          write_q <= bus.req_write;
          size_q <= bus.req_size;
          uns_q <= bus.req_unsigned;
          ofs_q <= bus.req_addr[1:0];
          addr_q <= {bus.req_addr[ADDR_W-1:2], 2'b00};
          wdata_q <= bus.req_wdata;
          mem_wdata_q <= bus.req_wdata;
          rdata_q <= '0;
          mis_q <= mis;
          cnt_q <= '0;
          state_q <= mis ? RESP : bus.req_write && bus.req_size == SZ_WORD ? WR : RD;
        end
        RD: if (cnt_q == CNT_LAST) begin
          rdata_q <= write_q ? '0 : load_data;
          mem_wdata_q <= merged;
          state_q <= write_q ? WR : RESP;
        end else cnt_q <= cnt_q + CW'(1);
        WR: state_q <= RESP;
        default: state_q <= IDLE;
      endcase
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench driving two units (READ_WAIT 0 and 2) against a
// byte-array reference memory; one unit is active at a time and they share the data memory.
module tb_mem_access_unit;
  typedef struct {
    int g;
    logic [31:0] rdata;
    logic mis;
    int cyc;
    int nrd;
    int nwr;
    logic [31:0] wa;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] rv = '0, rw = '0, ru = '0, rr, resv, misv, re, we;
  logic [1:0][1:0] rs = '0;
  logic [1:0][31:0] ra = '0, rwd = '0, rdat, ma, mwd;
  logic [31:0] mem [0:255];
  logic [7:0] refm [0:1023];
  exp_t sbq[$];
  int cyc = 0, checks = 0, failures = 0;
  int rdn [2], wrn [2];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int g = 0; g < 2; g++) if (we[g]) mem[ma[g][9:2]] <= mwd[g];
  end

  for (genvar g = 0; g < 2; g++) begin : u
    int rdcnt = 0;
    mem_access_unit_if #(.ADDR_W(32)) bus ();
    mem_access_unit #(.READ_WAIT(2 * g), .ADDR_W(32)) dut (.clk(clk), .reset(rst), .bus(bus));
    assign bus.req_valid = rv[g];
    assign bus.req_write = rw[g];
    assign bus.req_size = rs[g];
    assign bus.req_unsigned = ru[g];
    assign bus.req_addr = ra[g];
    assign bus.req_wdata = rwd[g];
    assign rr[g] = bus.req_ready;
    assign resv[g] = bus.resp_valid;
    assign rdat[g] = bus.resp_rdata;
    assign misv[g] = bus.resp_misaligned;
    assign ma[g] = bus.mem_address;
    assign mwd[g] = bus.mem_write_data;
    assign re[g] = bus.mem_read_en;
    assign we[g] = bus.mem_write_en;
    // Read data is garbage until the read enable has been held for READ_WAIT cycles
    assign bus.mem_read_data = rdcnt >= 2 * g ? mem[bus.mem_address[9:2]] : 32'hBAD0_BAD0;
    always @(posedge clk) rdcnt <= bus.mem_read_en ? rdcnt + 1 : 0;
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] refw(input int i);
    return {refm[4*i], refm[4*i+1], refm[4*i+2], refm[4*i+3]};
  endfunction

  // Reference: byte-addressed big-endian memory; latency counted from the accepting cycle
  task automatic model(input int g, input logic w, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] wd, input int acc);
    exp_t e;
    int n = 1 << sz;
    int rwait = 2 * g;
    int ai = int'(a);
    logic [31:0] v = '0;
    e.g = g;
    e.wa = a & ~32'd3;
    e.mis = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    e.rdata = '0;
    e.nrd = 0;
    e.nwr = 0;
    if (e.mis) e.cyc = acc + 1;
    else if (w) begin
      for (int i = 0; i < n; i++) refm[ai+i] = wd[8*(n-1-i) +: 8];
      e.nwr = 1;
      e.nrd = n == 4 ? 0 : rwait + 1;
      e.cyc = acc + 2 + e.nrd;
    end else begin
      for (int i = 0; i < n; i++) v = {v[23:0], refm[ai+i]};
      if (!un && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      e.rdata = v;
      e.nrd = rwait + 1;
      e.cyc = acc + 1 + e.nrd;
    end
    sbq.push_back(e);
  endtask

  task automatic issue(input int g, input logic w, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] wd, input bit track, output int acc);
    int t = 0;
    @(negedge clk);
    rv[g] = 1'b1; rw[g] = w; rs[g] = sz; ru[g] = un; ra[g] = a; rwd[g] = wd;
    while (!rr[g] && t < 50) begin @(negedge clk); t++; end
    chk("accept_ready", {31'b0, rr[g]}, 32'd1);
    if (!rr[g]) begin acc = -1; return; end
    acc = cyc;
    if (track) model(g, w, sz, un, a, wd, acc);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int g);
    int t = 0;
    @(negedge clk);
    rv[g] = 1'b0;
    while (sbq.size() != 0 && t < 100) begin @(negedge clk); t++; end
    chk("drain", sbq.size(), 0);
    @(negedge clk);
  endtask

  task automatic rand_txn(input int g);
    int acc;
    logic [1:0] sz = $urandom_range(0, 9) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
    issue(g, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 31)), $urandom, 1'b1, acc);
    if ($urandom_range(0, 2) == 0) begin
      @(negedge clk);
      rv[g] = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) for (int g = 0; g < 2; g++) begin rdn[g] = 0; wrn[g] = 0; end
      else for (int g = 0; g < 2; g++) begin
        if (re[g] || we[g]) begin
          chk("rd_wr_exclusive", {31'b0, re[g] & we[g]}, 32'd0);
          if (sbq.size() > 0 && sbq[0].g == g) chk("mem_address", ma[g], sbq[0].wa);
          if (re[g]) rdn[g]++;
          if (we[g]) wrn[g]++;
        end
        if (resv[g]) begin
          if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_resp dut=%0d got=resp want=none", g);
          end else begin
            e = sbq.pop_front();
            chk("resp_dut", g, e.g);
            chk("resp_rdata", rdat[g], e.rdata);
            chk("resp_misaligned", {31'b0, misv[g]}, {31'b0, e.mis});
            chk("resp_cycle", cyc, e.cyc);
            chk("read_en_cycles", rdn[g], e.nrd);
            chk("write_en_cycles", wrn[g], e.nwr);
          end
          rdn[g] = 0;
          wrn[g] = 0;
        end
      end
    end
  end

  initial begin
    int a1, a2, acc;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      for (int b = 0; b < 4; b++) refm[4*i+b] = mem[i][31-8*b -: 8];
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_ready", {31'b0, rr[g]}, 32'd1);
      chk("rst_outputs", {re[g], we[g], resv[g], misv[g]} == 4'b0 ? 32'd0 : 32'd1, 32'd0);
      chk("rst_addr", ma[g], 32'd0);
      chk("rst_wdata", mwd[g], 32'd0);
      chk("rst_rdata", rdat[g], 32'd0);
    end
    rst = 1'b0;
    issue(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, acc);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, acc);
    idle(0);
    chk("mem_after_sw", mem[4], 32'hDEADBEEF);
    issue(0, 1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_0055, 1'b1, acc);
    idle(0);
    chk("mem_after_sb", mem[4], 32'hDE55BEEF);
    issue(0, 1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 1'b1, acc);
    issue(0, 1'b0, 2'd0, 1'b0, 32'h12, 32'h0, 1'b1, acc);
    issue(0, 1'b0, 2'd0, 1'b1, 32'h12, 32'h0, 1'b1, acc);
    issue(0, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b1, acc);
    issue(0, 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b1, acc);
    issue(0, 1'b1, 2'd1, 1'b0, 32'h10, 32'h0000_1234, 1'b1, acc);
    idle(0);
    chk("mem_after_sh", mem[4], 32'h1234BEEF);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 1'b1, acc);
    issue(0, 1'b1, 2'd1, 1'b0, 32'h11, 32'hFFFF_FFFF, 1'b1, acc);
    issue(0, 1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 1'b1, acc);
    idle(0);
    issue(0, 1'b1, 2'd0, 1'b0, 32'h10, 32'h0000_0077, 1'b0, acc);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_outputs", {re[0], we[0], resv[0], misv[0]} == 4'b0 ? 32'd0 : 32'd1, 32'd0);
    chk("rst_mid_addr", ma[0], 32'd0);
    chk("rst_mid_wdata", mwd[0], 32'd0);
    chk("rst_mid_ready", {31'b0, rr[0]}, 32'd1);
    rv[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_no_write", wrn[0], 0);
    chk("rst_mem_kept", mem[4], refw(4));
    chk("rst_ready_after", {31'b0, rr[0]}, 32'd1);
    repeat (60) rand_txn(0);
    idle(0);
    issue(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, a1);
    issue(1, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b1, a2);
    chk("b2b_accept_cycle", a2, a1 + 5);
    idle(1);
    repeat (50) rand_txn(1);
    idle(1);
    for (int i = 0; i < 8; i++) chk("mem_final", mem[i], refw(i));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
